mem_stage: RTL

- MIPS pipeline memory stage. Sits directly downstream of the EX/MEM latch.
- Performs loads and stores against a handshaked data-memory port, with byte-lane alignment and load sign/zero extension.
- Stalls the upstream pipe while an access is outstanding.
- Registers results into the MEM/WB pipeline register feeding writeback.

---
 rtl/mem_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MIPS memory stage: aligns loads/stores onto a handshaked data port, stalls
// upstream while an access is outstanding, and feeds the MEM/WB register.
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread_M,
   input  logic        memwrite_M,
   input  logic        regwrite_M,
   input  logic        memtoreg_M,
   input  logic [1:0]  size_M,
   input  logic        unsigned_M,
   input  logic [31:0] aluresult_M,
   input  logic [31:0] writedata_M,
   input  logic [4:0]  writereg_M,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall_M,
   output logic        misalign_M,
   output logic        buserr_M,
   output logic        regwrite_W,
   output logic        memtoreg_W,
   output logic [31:0] readdata_W,
   output logic [31:0] aluresult_W,
   output logic [4:0]  writereg_W
);

   localparam int NUM_LANES = 4;
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic           memop, misaligned, at_limit, timeout, load_done;
   logic [1:0]     ofs;
   logic [7:0]     ld_byte;
   logic [15:0]    ld_half;
   logic [31:0]    ld_data;
   logic [NUM_LANES-1:0][7:0] wlane;

   assign ofs        = aluresult_M[1:0];
   assign memop      = memread_M | memwrite_M;
   assign misaligned = memop & (((size_M == 2'b01) & ofs[0]) |
                                (size_M[1] & (ofs != 2'b00)));

   // The limit cycle is not a stall: an ack there completes, otherwise the
   // instruction retires as a bus error and upstream advances.
   assign at_limit  = (state == BUSY) && (cnt == CW'(TIMEOUT));
   assign timeout   = at_limit & ~dmem_ack;

   assign dmem_req   = (state == BUSY) | (memop & ~misaligned);
   assign dmem_we    = memwrite_M & dmem_req;
   assign dmem_addr  = {aluresult_M[31:2], 2'b00};
   assign stall_M    = dmem_req & ~dmem_ack & ~at_limit;
   assign misalign_M = misaligned & ~reset;
   assign buserr_M   = timeout & ~reset;
   assign load_done  = memread_M & dmem_req & dmem_ack;

   always_comb begin
      case (size_M)
         2'b00:   dmem_be = 4'b0001 << ofs;
         2'b01:   dmem_be = ofs[1] ? 4'b1100 : 4'b0011;
         default: dmem_be = 4'b1111;
      endcase
   end

   // Replicate store data so each enabled lane sees its bytes in place.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign wlane[i] = (size_M == 2'b00) ? writedata_M[7:0] :
                        (size_M == 2'b01) ? writedata_M[8*(i%2) +: 8] :
                                            writedata_M[8*i +: 8];
   end
   assign dmem_wdata = wlane;

   assign ld_byte = dmem_rdata[8*ofs +: 8];
   assign ld_half = ofs[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      case (size_M)
         2'b00:   ld_data = unsigned_M ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = unsigned_M ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (dmem_req && !dmem_ack) begin
               state_nx = BUSY;
               cnt_nx   = CW'(1);
            end
         end
         BUSY: begin
            if (dmem_ack || at_limit) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regwrite_W  <= 1'b0;
         memtoreg_W  <= 1'b0;
         readdata_W  <= '0;
         aluresult_W <= '0;
         writereg_W  <= '0;
      end else if (stall_M) begin
         regwrite_W <= 1'b0;
         memtoreg_W <= 1'b0;
      end else begin
         regwrite_W  <= regwrite_M & ~misaligned & ~timeout;
         memtoreg_W  <= memtoreg_M;
         aluresult_W <= aluresult_M;
         writereg_W  <= writereg_M;
         if (load_done) readdata_W <= ld_data;
      end
   end

endmodule
